// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants for the pipelined MIPS core.
package cpu_pkg;
    localparam int PC_WIDTH_DEF = 8;
    localparam int INST_WIDTH_DEF = 32;
    localparam logic [INST_WIDTH_DEF-1:0] HALT_WORD_DEF = '1;
    localparam logic [INST_WIDTH_DEF-1:0] NOP = '0;
    typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_e;
endpackage

// File: rtl/inst_memory.sv
// inst_memory: instruction store with one synchronous write port and one combinational read port.
module inst_memory #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    // Addresses beyond the populated depth drop writes and read as zero.
    always_ff @(posedge clk)
        if (we && int'(wr_addr) < DEPTH) mem[wr_addr[IDX_W-1:0]] <= wr_data;
    assign rd_data = int'(rd_addr) < DEPTH ? mem[rd_addr[IDX_W-1:0]] : '0;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage with PC, loadable instruction memory, IF/ID register and
// load/run/halt control for the debug unit.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF,
    parameter int INST_WIDTH = INST_WIDTH_DEF,
    parameter int MEM_DEPTH = 256,
    parameter logic [INST_WIDTH-1:0] HALT_WORD = {INST_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  pc_src,
    input  logic [PC_WIDTH-1:0]   pc_branch,
    input  logic                  write_inst_mem,
    input  logic [PC_WIDTH-1:0]   inst_mem_addr,
    input  logic [INST_WIDTH-1:0] inst_mem_data,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [PC_WIDTH-1:0]   pc_next,
    output logic [INST_WIDTH-1:0] instruction,
    output logic                  inst_valid,
    output logic                  halted
);
    localparam logic [INST_WIDTH-1:0] BUBBLE = INST_WIDTH'(NOP);
    fetch_state_e state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, pc_next_q, pc_next_d, pc_inc;
    logic [INST_WIDTH-1:0] instruction_q, instruction_d, mem_rdata;
    logic inst_valid_q, inst_valid_d, halted_q, halted_d, mem_we;

    inst_memory #(.ADDR_WIDTH(PC_WIDTH), .DATA_WIDTH(INST_WIDTH), .DEPTH(MEM_DEPTH)) u_mem (
        .clk(clk), .we(mem_we), .wr_addr(inst_mem_addr), .wr_data(inst_mem_data),
        .rd_addr(pc_q), .rd_data(mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        pc_next_d = pc_next_q;
        instruction_d = instruction_q;
        inst_valid_d = inst_valid_q;
        halted_d = halted_q;
        mem_we = 1'b0;
        pc_inc = pc_q + 1'b1;
        case (state_q)
            IDLE: begin
                mem_we = write_inst_mem;
                if (enable && !write_inst_mem) state_d = RUN;
            end
            RUN: if (enable) begin
                pc_d = pc_src ? pc_branch : (stall ? pc_q : pc_inc);
                if (flush) begin
                    instruction_d = BUBBLE;
                    inst_valid_d = 1'b0;
                end else if (!stall) begin
                    instruction_d = mem_rdata;
                    pc_next_d = pc_inc;
                    inst_valid_d = 1'b1;
                    // The halt word parks the PC on itself so the debug unit sees where it stopped.
                    if (mem_rdata == HALT_WORD) begin
                        state_d = HALTED;
                        halted_d = 1'b1;
                        if (!pc_src) pc_d = pc_q;
                    end
                end
            end
            default: if (enable && !stall) begin
                instruction_d = BUBBLE;
                inst_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q <= '0;
            pc_next_q <= '0;
            instruction_q <= '0;
            inst_valid_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            pc_next_q <= pc_next_d;
            instruction_q <= instruction_d;
            inst_valid_q <= inst_valid_d;
            halted_q <= halted_d;
        end
    end

    assign pc = pc_q;
    assign pc_next = pc_next_q;
    assign instruction = instruction_q;
    assign inst_valid = inst_valid_q;
    assign halted = halted_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: table-driven checks of fetch, branch, stall, flush, halt and reset.
module tb_instruction_fetch_unit;
    localparam logic [31:0] H = 32'hFFFF_FFFF;

    typedef struct {
        logic en, st, fl, src;
        logic [7:0] br;
        logic we;
        logic [31:0] ins;
        logic [7:0] pc, pcn;
        logic v, h;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0, enable = 1'b0, stall = 1'b0, flush = 1'b0, pc_src = 1'b0;
    logic write_inst_mem = 1'b0;
    logic [7:0] pc_branch = '0, inst_mem_addr = '0, pc, pc_next;
    logic [31:0] inst_mem_data = '0, instruction;
    logic inst_valid, halted;
    int total = 0, passed = 0;
    vec_t run1[$], run3[$], sb[$];

    instruction_fetch_unit #(.PC_WIDTH(8), .INST_WIDTH(32), .MEM_DEPTH(64)) dut (
        .clk(clk), .rst(rst), .enable(enable), .stall(stall), .flush(flush), .pc_src(pc_src),
        .pc_branch(pc_branch), .write_inst_mem(write_inst_mem), .inst_mem_addr(inst_mem_addr),
        .inst_mem_data(inst_mem_data), .pc(pc), .pc_next(pc_next), .instruction(instruction),
        .inst_valid(inst_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic vec_t mk(logic en, logic st, logic fl, logic src, logic [7:0] br, logic we,
                                logic [31:0] ins, logic [7:0] pc_e, logic [7:0] pcn, logic v, logic h);
        vec_t r;
        r.en = en; r.st = st; r.fl = fl; r.src = src; r.br = br; r.we = we;
        r.ins = ins; r.pc = pc_e; r.pcn = pcn; r.v = v; r.h = h;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic apply(string tag, int idx, vec_t s);
        vec_t e;
        @(negedge clk);
        enable = s.en; stall = s.st; flush = s.fl; pc_src = s.src; pc_branch = s.br;
        write_inst_mem = s.we; inst_mem_addr = 8'd2; inst_mem_data = 32'h99;
        sb.push_back(s);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("%s[%0d].pc", tag, idx), 32'(pc), 32'(e.pc));
        chk($sformatf("%s[%0d].pc_next", tag, idx), 32'(pc_next), 32'(e.pcn));
        chk($sformatf("%s[%0d].instruction", tag, idx), instruction, e.ins);
        chk($sformatf("%s[%0d].inst_valid", tag, idx), 32'(inst_valid), 32'(e.v));
        chk($sformatf("%s[%0d].halted", tag, idx), 32'(halted), 32'(e.h));
    endtask

    task automatic load(logic [7:0] a, logic [31:0] d);
        @(negedge clk);
        write_inst_mem = 1'b1; inst_mem_addr = a; inst_mem_data = d;
        @(posedge clk);
        #1 write_inst_mem = 1'b0;
    endtask

    task automatic rst_pulse(string tag);
        @(negedge clk);
        {enable, stall, flush, pc_src, write_inst_mem} = '0;
        rst = 1'b1;
        #1;
        chk({tag, ".pc"}, 32'(pc), 0);
        chk({tag, ".pc_next"}, 32'(pc_next), 0);
        chk({tag, ".instruction"}, instruction, 0);
        chk({tag, ".inst_valid"}, 32'(inst_valid), 0);
        chk({tag, ".halted"}, 32'(halted), 0);
        #1 rst = 1'b0;
    endtask

    initial begin
        run1.push_back(mk(1,0,0,0,8'h00,0, 0,   8'd0, 8'd0, 0,0));
        run1.push_back(mk(1,0,0,0,8'h00,0, 10,  8'd1, 8'd1, 1,0));
        run1.push_back(mk(1,0,0,0,8'h00,0, 20,  8'd2, 8'd2, 1,0));
        run1.push_back(mk(1,0,0,0,8'h00,0, 30,  8'd3, 8'd3, 1,0));
        run1.push_back(mk(1,0,0,0,8'h00,0, H,   8'd3, 8'd4, 1,1));
        run1.push_back(mk(1,0,0,0,8'h00,0, 0,   8'd3, 8'd4, 0,1));
        run1.push_back(mk(1,0,0,1,8'd10,0, 0,   8'd3, 8'd4, 0,1));

        run3.push_back(mk(1,0,0,0,8'h00,0, 0,     8'd0,  8'd0,  0,0));
        run3.push_back(mk(1,0,0,0,8'h00,0, 10,    8'd1,  8'd1,  1,0));
        run3.push_back(mk(1,0,0,0,8'h00,0, 20,    8'd2,  8'd2,  1,0));
        run3.push_back(mk(1,0,1,1,8'h40,0, 0,     8'h40, 8'd2,  0,0));
        run3.push_back(mk(1,0,0,0,8'h00,0, 0,     8'h41, 8'h41, 1,0));
        run3.push_back(mk(1,0,0,1,8'd10,0, 0,     8'd10, 8'h42, 1,0));
        run3.push_back(mk(1,0,0,0,8'h00,0, 'hA0,  8'd11, 8'd11, 1,0));
        for (int i = 0; i < 3; i++)
            run3.push_back(mk(1,1,0,0,8'h00,0, 'hA0, 8'd11, 8'd11, 1,0));
        run3.push_back(mk(1,1,0,1,8'd36,0, 'hA0,  8'd36, 8'd11, 1,0));
        run3.push_back(mk(1,0,0,0,8'h00,0, 'h36,  8'd37, 8'd37, 1,0));
        run3.push_back(mk(1,0,0,1,8'hFF,0, 'h37,  8'hFF, 8'd38, 1,0));
        run3.push_back(mk(1,0,0,0,8'h00,0, 0,     8'h00, 8'h00, 1,0));
        run3.push_back(mk(0,0,1,1,8'd5, 0, 0,     8'h00, 8'h00, 1,0));
        run3.push_back(mk(0,0,0,0,8'h00,0, 0,     8'h00, 8'h00, 1,0));
        run3.push_back(mk(1,0,0,0,8'h00,0, 10,    8'd1,  8'd1,  1,0));
        run3.push_back(mk(1,0,0,0,8'h00,1, 20,    8'd2,  8'd2,  1,0));
        run3.push_back(mk(1,0,0,0,8'h00,0, 30,    8'd3,  8'd3,  1,0));
        run3.push_back(mk(1,1,1,0,8'h00,0, 0,     8'd3,  8'd3,  0,0));
        run3.push_back(mk(1,0,0,0,8'h00,0, H,     8'd3,  8'd4,  1,1));
        run3.push_back(mk(1,1,0,0,8'h00,0, H,     8'd3,  8'd4,  1,1));
        run3.push_back(mk(1,0,0,1,8'd10,0, 0,     8'd3,  8'd4,  0,1));

        rst_pulse("reset_init");
        load(8'd0, 32'd10);
        load(8'd1, 32'd20);
        load(8'd2, 32'd30);
        load(8'd3, H);
        load(8'd10, 32'hA0);
        load(8'd36, 32'h36);
        load(8'd37, 32'h37);
        load(8'd100, 32'hDEAD);

        foreach (run1[i]) apply("program", i, run1[i]);
        rst_pulse("reset_halted");
        apply("restart", 0, run1[0]);
        apply("restart", 1, run1[1]);
        rst_pulse("reset_midrun");
        foreach (run3[i]) apply("replay", i, run3[i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
